// File: rtl/lab3_mem_refill_arbiter.sv
// Round-robin arbiter sharing one 16B memory port between two requesters, with in-order response routing.
// Zero added latency on both paths; requesters stall while p_max_outstanding requests are in flight or memory is not ready.
module lab3_mem_refill_arbiter #(
  parameter int p_max_outstanding = 4,
  parameter int p_req_nbits       = 175,
  parameter int p_resp_nbits      = 145
)(
  input  logic                    clk,
  input  logic                    reset,

  input  logic [p_req_nbits-1:0]  req0_msg,
  input  logic                    req0_val,
  output logic                    req0_rdy,
  output logic [p_resp_nbits-1:0] resp0_msg,
  output logic                    resp0_val,
  input  logic                    resp0_rdy,

  input  logic [p_req_nbits-1:0]  req1_msg,
  input  logic                    req1_val,
  output logic                    req1_rdy,
  output logic [p_resp_nbits-1:0] resp1_msg,
  output logic                    resp1_val,
  input  logic                    resp1_rdy,

  output logic [p_req_nbits-1:0]  memreq_msg,
  output logic                    memreq_val,
  input  logic                    memreq_rdy,
  input  logic [p_resp_nbits-1:0] memresp_msg,
  input  logic                    memresp_val,
  output logic                    memresp_rdy
);

  localparam int c_ptr_nbits = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
  localparam int c_cnt_nbits = $clog2(p_max_outstanding + 1);
  localparam logic [c_ptr_nbits-1:0] c_last_ptr = c_ptr_nbits'(p_max_outstanding - 1);
  localparam logic [c_cnt_nbits-1:0] c_max_cnt  = c_cnt_nbits'(p_max_outstanding);

  logic [p_max_outstanding-1:0] route_q;
  logic [c_ptr_nbits-1:0]       head_ptr;
  logic [c_ptr_nbits-1:0]       tail_ptr;
  logic [c_cnt_nbits-1:0]       count;
  logic                         prio;

  logic can_issue;
  logic head_vld;
  logic head_id;
  logic grant_vld;
  logic grant;
  logic req_xfer;
  logic resp_xfer;

  function automatic logic [c_ptr_nbits-1:0] next_ptr(input logic [c_ptr_nbits-1:0] ptr);
    next_ptr = (ptr == c_last_ptr) ? '0 : ptr + 1'b1;
  endfunction

  // Full blocks enqueue even when a dequeue happens in the same cycle.
  assign can_issue = (count < c_max_cnt);
  assign head_vld  = (count != '0);
  assign head_id   = route_q[head_ptr];

  always_comb begin
    grant_vld = can_issue && (req0_val || req1_val);
    grant     = (req0_val && req1_val) ? prio : req1_val;
  end

  assign memreq_msg = (grant_vld && grant) ? req1_msg : req0_msg;
  assign memreq_val = reset && grant_vld;
  assign req0_rdy   = reset && memreq_rdy && grant_vld && !grant;
  assign req1_rdy   = reset && memreq_rdy && grant_vld &&  grant;
  assign req_xfer   = memreq_val && memreq_rdy;

  assign resp0_msg   = memresp_msg;
  assign resp1_msg   = memresp_msg;
  assign resp0_val   = reset && head_vld && !head_id && memresp_val;
  assign resp1_val   = reset && head_vld &&  head_id && memresp_val;
  assign memresp_rdy = reset && head_vld && (head_id ? resp1_rdy : resp0_rdy);
  assign resp_xfer   = memresp_val && memresp_rdy;

  always_ff @(posedge clk) begin
    if (req_xfer) begin
      route_q[tail_ptr] <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      prio     <= 1'b0;
    end else begin
      if (req_xfer) begin
        tail_ptr <= next_ptr(tail_ptr);
        prio     <= !grant;
      end
      if (resp_xfer) begin
        head_ptr <= next_ptr(head_ptr);
      end
      case ({req_xfer, resp_xfer})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_lab3_mem_refill_arbiter.sv
// Directed bench for lab3_mem_refill_arbiter: vector table plus hand sequences for contention, full queue, backpressure and reset.
module tb_lab3_mem_refill_arbiter;

  typedef struct packed {
    logic [2:0]   typ;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_t;

  typedef struct packed {
    logic [2:0]   typ;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_t;

  typedef struct {
    logic r0v, r1v, mrdy, mrv, rr0, rr1;
    logic e_mqv, e_r0rdy, e_r1rdy, e_mrrdy, e_rs0v, e_rs1v, e_sel;
  } vec_t;

  logic      clk = 1'b0;
  logic      reset = 1'b0;
  mem_req_t  req0_msg, req1_msg, memreq_msg;
  mem_resp_t resp0_msg, resp1_msg, memresp_msg;
  logic      req0_val, req0_rdy, resp0_val, resp0_rdy;
  logic      req1_val, req1_rdy, resp1_val, resp1_rdy;
  logic      memreq_val, memreq_rdy, memresp_val, memresp_rdy;

  mem_req_t  m0, m1;
  mem_resp_t rsp;
  int        n_chk = 0;
  int        n_fail = 0;
  vec_t      vt[10];

  lab3_mem_refill_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_msg    (req0_msg),
    .req0_val    (req0_val),
    .req0_rdy    (req0_rdy),
    .resp0_msg   (resp0_msg),
    .resp0_val   (resp0_val),
    .resp0_rdy   (resp0_rdy),
    .req1_msg    (req1_msg),
    .req1_val    (req1_val),
    .req1_rdy    (req1_rdy),
    .resp1_msg   (resp1_msg),
    .resp1_val   (resp1_val),
    .resp1_rdy   (resp1_rdy),
    .memreq_msg  (memreq_msg),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memresp_msg (memresp_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [199:0] act, input logic [199:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r0v, input logic r1v, input logic mrdy,
                       input logic mrv, input logic rr0, input logic rr1);
    req0_val    = r0v;
    req1_val    = r1v;
    memreq_rdy  = mrdy;
    memresp_val = mrv;
    resp0_rdy   = rr0;
    resp1_rdy   = rr1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk1({pfx, "_memreq_val"},  memreq_val,  1'b0);
    chk1({pfx, "_memresp_rdy"}, memresp_rdy, 1'b0);
    chk1({pfx, "_req0_rdy"},    req0_rdy,    1'b0);
    chk1({pfx, "_req1_rdy"},    req1_rdy,    1'b0);
    chk1({pfx, "_resp0_val"},   resp0_val,   1'b0);
    chk1({pfx, "_resp1_val"},   resp1_val,   1'b0);
  endtask

  initial begin
    int acc;
    int sent0, sent1, k, cyc, id;
    int exp_q[$];
    logic g;

    m0  = '{typ: 3'd0, opaque: 8'h05, addr: 32'h0000_1000, len: 4'd0, data: 128'h0};
    m1  = '{typ: 3'd1, opaque: 8'hA1, addr: 32'h0000_2000, len: 4'd0,
            data: 128'h1111_2222_3333_4444_5555_6666_7777_8888};
    rsp = '{typ: 3'd0, opaque: 8'h05, test: 2'd0, len: 4'd0,
            data: 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF};
    req0_msg    = m0;
    req1_msg    = m1;
    memresp_msg = rsp;

    //             r0v r1v mrdy mrv rr0 rr1 | mqv r0rdy r1rdy mrrdy rs0v rs1v sel
    vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    // Outputs held low while reset is asserted, even with every input active.
    reset = 1'b0;
    drive(1, 1, 1, 1, 1, 1);
    #2;
    chk_all_zero("rst0");
    step();
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].r0v, vt[i].r1v, vt[i].mrdy, vt[i].mrv, vt[i].rr0, vt[i].rr1);
      #2;
      chk1($sformatf("v%0d_memreq_val", i),  memreq_val,  vt[i].e_mqv);
      chk1($sformatf("v%0d_req0_rdy", i),    req0_rdy,    vt[i].e_r0rdy);
      chk1($sformatf("v%0d_req1_rdy", i),    req1_rdy,    vt[i].e_r1rdy);
      chk1($sformatf("v%0d_memresp_rdy", i), memresp_rdy, vt[i].e_mrrdy);
      chk1($sformatf("v%0d_resp0_val", i),   resp0_val,   vt[i].e_rs0v);
      chk1($sformatf("v%0d_resp1_val", i),   resp1_val,   vt[i].e_rs1v);
      if (vt[i].e_mqv)
        chkw($sformatf("v%0d_memreq_msg", i), 200'(memreq_msg), vt[i].e_sel ? 200'(m1) : 200'(m0));
      chkw($sformatf("v%0d_resp0_msg", i), 200'(resp0_msg), 200'(rsp));
      chkw($sformatf("v%0d_resp1_msg", i), 200'(resp1_msg), 200'(rsp));
      step();
    end

    // Single requester read with a response one cycle later.
    do_reset();
    drive(1, 0, 1, 0, 1, 1);
    #2;
    chk1("single_memreq_val", memreq_val, 1'b1);
    chk1("single_req0_rdy", req0_rdy, 1'b1);
    chkw("single_memreq_msg", 200'(memreq_msg), 200'(m0));
    step();
    drive(0, 0, 1, 1, 1, 1);
    #2;
    chk1("single_resp0_val", resp0_val, 1'b1);
    chk1("single_resp1_val", resp1_val, 1'b0);
    chk1("single_memresp_rdy", memresp_rdy, 1'b1);
    chkw("single_resp0_opaque", 200'(resp0_msg.opaque), 200'(8'h05));
    chkw("single_resp0_data", 200'(resp0_msg.data), 200'(rsp.data));
    step();

    // Contention: 4 requests each, memory answers the cycle after acceptance.
    do_reset();
    sent0 = 0;
    sent1 = 0;
    k = 0;
    cyc = 0;
    exp_q.delete();
    while (!(k == 8 && exp_q.size() == 0) && cyc < 40) begin
      drive(sent0 < 4, sent1 < 4, 1, exp_q.size() > 0, 1, 1);
      #2;
      if (memresp_val) begin
        id = exp_q.pop_front();
        chk1($sformatf("cont_resp0_val_%0d", cyc), resp0_val, id == 0);
        chk1($sformatf("cont_resp1_val_%0d", cyc), resp1_val, id == 1);
        chk1($sformatf("cont_memresp_rdy_%0d", cyc), memresp_rdy, 1'b1);
      end
      if (req0_rdy || req1_rdy) begin
        g = req1_rdy;
        chk1($sformatf("cont_grant_%0d", k), g, k[0]);
        if (g) sent1++;
        else   sent0++;
        exp_q.push_back(k % 2);
        k++;
      end
      step();
      cyc++;
    end
    chkw("cont_done_grants", 200'(k), 200'(8));
    chkw("cont_pending_left", 200'(exp_q.size()), 200'(0));

    // Queue full: memory silent, both requesters valid.
    do_reset();
    acc = 0;
    drive(1, 1, 1, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      #2;
      if (req0_rdy || req1_rdy) acc++;
      step();
    end
    chkw("full_accepted", 200'(acc), 200'(4));
    drive(1, 1, 1, 1, 1, 1);
    #2;
    chk1("full_memresp_rdy", memresp_rdy, 1'b1);
    chk1("full_resp0_val", resp0_val, 1'b1);
    chk1("full_nobypass_req0_rdy", req0_rdy, 1'b0);
    chk1("full_nobypass_req1_rdy", req1_rdy, 1'b0);
    step();
    drive(1, 1, 1, 0, 1, 1);
    #2;
    chk1("full_fifth_req0_rdy", req0_rdy, 1'b1);
    chk1("full_fifth_req1_rdy", req1_rdy, 1'b0);
    step();

    // Head is now requester 1; hold its response ready low for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 1, 0);
      #2;
      chk1($sformatf("bp_memresp_rdy_%0d", i), memresp_rdy, 1'b0);
      chk1($sformatf("bp_resp0_val_%0d", i), resp0_val, 1'b0);
      chk1($sformatf("bp_resp1_val_%0d", i), resp1_val, 1'b1);
      step();
    end
    drive(0, 0, 1, 1, 1, 1);
    #2;
    chk1("bp_release_memresp_rdy", memresp_rdy, 1'b1);
    chk1("bp_release_resp1_val", resp1_val, 1'b1);
    step();
    drive(0, 0, 1, 1, 0, 1);
    #2;
    chk1("bp_next_resp0_val", resp0_val, 1'b1);
    chk1("bp_next_resp1_val", resp1_val, 1'b0);
    chk1("bp_next_memresp_rdy", memresp_rdy, 1'b0);
    step();

    // Reset with two requests in flight.
    do_reset();
    drive(1, 1, 1, 0, 1, 1);
    step();
    step();
    reset = 1'b0;
    drive(1, 1, 1, 1, 1, 1);
    #2;
    chk_all_zero("rstmid");
    step();
    reset = 1'b1;
    drive(0, 0, 1, 1, 1, 1);
    #2;
    chk1("postrst_memresp_rdy", memresp_rdy, 1'b0);
    chk1("postrst_resp0_val", resp0_val, 1'b0);
    chk1("postrst_resp1_val", resp1_val, 1'b0);
    chk1("postrst_memreq_val", memreq_val, 1'b0);
    step();
    drive(1, 1, 1, 0, 1, 1);
    #2;
    chk1("postrst_req0_rdy", req0_rdy, 1'b1);
    chk1("postrst_req1_rdy", req1_rdy, 1'b0);
    chkw("postrst_memreq_msg", 200'(memreq_msg), 200'(m0));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
